// File: rtl/clk_div_gen.sv
// rtl/clk_div_gen.sv - multi-channel clock-enable / divided-clock generator with stretched reset
// Optional build macro: CLKDIV_RST_SYNC_EN (2-flop synchroniser on rst_i release before the hold counter)
module clk_div_gen #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2,
  parameter int RST_HOLD    = 16,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cfg_we_i,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [DIV_W-1:0]  cfg_div_i,
  input  logic              sync_i,
  output logic [NUM_CH-1:0] ce_o,
  output logic [NUM_CH-1:0] clk_o,
  output logic              rst_o,
  output logic              locked_o
);

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  logic [15:0]       hold_q, hold_d;
  logic              rst_q, rst_d;
  logic              locked_q, locked_d;
  logic              hold_run;
  logic [NUM_CH-1:0] pend_vec;

`ifdef CLKDIV_RST_SYNC_EN
  logic [1:0] sync_rst_q, sync_rst_d;
  assign sync_rst_d = {sync_rst_q[0], 1'b0};
  // Release of rst_i is retimed through two flops; assertion stays asynchronous
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_rst_q <= 2'b11;
    else       sync_rst_q <= sync_rst_d;
  end
  assign hold_run = ~sync_rst_q[1];
`else
  assign hold_run = 1'b1;
`endif

  // Hold counter: keep rst_o high for RST_HOLD counting cycles, then stop
  always_comb begin
    hold_d = hold_q;
    rst_d  = rst_q;
    if (rst_q && hold_run) begin
      hold_d = hold_q + 16'd1;
      rst_d  = (({1'b0, hold_q} + 17'd1) < 17'(RST_HOLD));
    end
  end

  // Lock is reported one cycle after the reset/pending state it reflects
  always_comb begin
    locked_d = ~rst_q & ~(|pend_vec);
  end

  // Global reset-stretch and lock state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_q   <= '0;
      rst_q    <= 1'b1;
      locked_q <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      rst_q    <= rst_d;
      locked_q <= locked_d;
    end
  end

  assign rst_o    = rst_q;
  assign locked_o = locked_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pdiv_q, pdiv_d;
    logic [DIV_W-1:0] div_m1;
    logic [DIV_W:0]   half_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             hit, wrap;

    assign div_m1 = div_q - DIV_ONE;
    assign hit    = cfg_we_i & (cfg_ch_i == CH_W'(g));
    // Ratios 0 and 1 have no real period, so every cycle counts as a boundary
    assign wrap   = (div_q <= DIV_ONE) | (cnt_q == div_m1);

    // Counter advance and ratio hand-over at period boundaries or on sync_i
    always_comb begin
      cnt_d  = cnt_q;
      div_d  = div_q;
      pdiv_d = pdiv_q;
      pend_d = pend_q;
      if (rst_q) begin
        cnt_d = '0;
      end else if (sync_i || wrap) begin
        cnt_d = '0;
        if (hit) begin
          div_d  = cfg_div_i;
          pend_d = 1'b0;
        end else if (pend_q) begin
          div_d  = pdiv_q;
          pend_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + DIV_ONE;
        if (hit) begin
          pdiv_d = cfg_div_i;
          pend_d = 1'b1;
        end
      end
    end

    // Divided clock is registered from the next count so it never glitches
    assign half_d = ({1'b0, div_d} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
    assign clk_d  = ~rst_d & (div_d > DIV_ONE) & ({1'b0, cnt_d} < half_d);

    // Per-channel state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt_q  <= '0;
        div_q  <= DIV_RST;
        pdiv_q <= '0;
        pend_q <= 1'b0;
        clk_q  <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        div_q  <= div_d;
        pdiv_q <= pdiv_d;
        pend_q <= pend_d;
        clk_q  <= clk_d;
      end
    end

    assign ce_o[g]     = ~rst_q & ((div_q == DIV_ONE) | ((div_q > DIV_ONE) & (cnt_q == div_m1)));
    assign clk_o[g]    = clk_q;
    assign pend_vec[g] = pend_q;
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// tb/tb_clk_div_gen.sv - self-checking bench for clk_div_gen
module tb_clk_div_gen;
  localparam int NUM_CH      = 2;
  localparam int DIV_W       = 8;
  localparam int DEFAULT_DIV = 2;
  localparam int RST_HOLD    = 16;
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
`ifdef CLKDIV_RST_SYNC_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              cfg_we_i;
  logic [CH_W-1:0]   cfg_ch_i;
  logic [DIV_W-1:0]  cfg_div_i;
  logic              sync_i;
  logic [NUM_CH-1:0] ce_o, clk_o;
  logic              rst_o, locked_o;

  clk_div_gen #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV), .RST_HOLD(RST_HOLD)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_we_i(cfg_we_i), .cfg_ch_i(cfg_ch_i),
    .cfg_div_i(cfg_div_i), .sync_i(sync_i), .ce_o(ce_o), .clk_o(clk_o),
    .rst_o(rst_o), .locked_o(locked_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: ratio, pending ratio and position within the current period
  int m_div [NUM_CH];
  int m_pdiv[NUM_CH];
  int m_ph  [NUM_CH];
  bit m_pend[NUM_CH];
  int m_rel;
  bit m_locked;

  logic [NUM_CH-1:0] last_ce, last_clk;
  logic              last_rst, last_locked;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_div[i] = DEFAULT_DIV; m_pdiv[i] = 0; m_ph[i] = 0; m_pend[i] = 0;
    end
    m_rel = 0;
    m_locked = 0;
  endtask

  function automatic logic [2*NUM_CH+1:0] model_out();
    logic [NUM_CH-1:0] ce, ck;
    bit r;
    r = (m_rel < RST_HOLD + EXTRA);
    for (int i = 0; i < NUM_CH; i++) begin
      ce[i] = !r && (m_div[i] == 1 || (m_div[i] >= 2 && m_ph[i] == m_div[i] - 1));
      ck[i] = !r && m_div[i] >= 2 && m_ph[i] < (m_div[i] + 1) / 2;
    end
    return {r, m_locked, ce, ck};
  endfunction

  task automatic model_update(input bit we, input int ch, input int dv, input bit sy);
    bit r, any, hit, bnd;
    if (rst_i) begin
      model_reset();
      return;
    end
    r = (m_rel < RST_HOLD + EXTRA);
    any = 0;
    for (int i = 0; i < NUM_CH; i++) any |= m_pend[i];
    m_locked = !r && !any;
    if (r) begin
      m_rel++;
      for (int i = 0; i < NUM_CH; i++) m_ph[i] = 0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        hit = we && (ch == i);
        bnd = sy || m_div[i] <= 1 || m_ph[i] == m_div[i] - 1;
        if (bnd) begin
          if (hit) begin m_div[i] = dv; m_pend[i] = 0; end
          else if (m_pend[i]) begin m_div[i] = m_pdiv[i]; m_pend[i] = 0; end
          m_ph[i] = 0;
        end else begin
          m_ph[i]++;
          if (hit) begin m_pdiv[i] = dv; m_pend[i] = 1; end
        end
      end
    end
  endtask

  // One bus cycle: drive, sample mid-cycle against the model, advance model at the edge
  task automatic step(input bit we, input int ch, input int dv, input bit sy);
    int chm;
    chm = ch % (1 << CH_W);
    cfg_we_i  = we;
    cfg_ch_i  = CH_W'(chm);
    cfg_div_i = DIV_W'(dv);
    sync_i    = sy;
    @(negedge clk_i);
    last_ce = ce_o; last_clk = clk_o; last_rst = rst_o; last_locked = locked_o;
    check("model", 32'({rst_o, locked_o, ce_o, clk_o}), 32'(model_out()));
    @(posedge clk_i);
    model_update(we, chm, dv & ((1 << DIV_W) - 1), sy);
    cyc++;
    #1;
    cfg_we_i = 1'b0;
    sync_i   = 1'b0;
  endtask

  task automatic measure_period(input int ch, output int per);
    int first;
    first = -1;
    per   = -1;
    for (int k = 0; k < 600; k++) begin
      step(0, 0, 0, 0);
      if (last_ce[ch]) begin
        if (first < 0) first = k;
        else begin
          per = k - first;
          break;
        end
      end
    end
  endtask

  typedef struct {
    bit         we;
    int         ch;
    int         dv;
    bit         sy;
    logic [1:0] ce;
    logic [1:0] ck;
    bit         lk;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int per, both, first_both, cnt_ce, cnt_clk;
    bit lk_ok;

    tbl[0] = '{0, 0, 0, 0, 2'b00, 2'b11, 0};
    tbl[1] = '{0, 0, 0, 0, 2'b11, 2'b00, 1};
    tbl[2] = '{1, 1, 5, 0, 2'b00, 2'b11, 1};
    tbl[3] = '{0, 0, 0, 0, 2'b11, 2'b00, 1};
    tbl[4] = '{0, 0, 0, 0, 2'b00, 2'b11, 0};
    tbl[5] = '{0, 0, 0, 0, 2'b01, 2'b10, 1};
    tbl[6] = '{0, 0, 0, 0, 2'b00, 2'b11, 1};
    tbl[7] = '{0, 0, 0, 0, 2'b01, 2'b00, 1};
    tbl[8] = '{0, 0, 0, 0, 2'b10, 2'b01, 1};
    tbl[9] = '{0, 0, 0, 0, 2'b01, 2'b10, 1};

    rst_i = 1'b1; cfg_we_i = 1'b0; cfg_ch_i = '0; cfg_div_i = '0; sync_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    check("reset_state", 32'({rst_o, locked_o, ce_o, clk_o}), 32'({1'b1, 1'b0, 2'b00, 2'b00}));
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Hold phase: rst_o must stay high for exactly RST_HOLD(+2) cycles
    for (int k = 0; k < RST_HOLD + EXTRA; k++) step(0, 0, 0, 0);
    check("rst_fall", 32'({last_rst, rst_o}), 32'(2'b10));

    // Directed table from the first cycle with rst_o low
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].we, tbl[i].ch, tbl[i].dv, tbl[i].sy);
      check("table", 32'({last_ce, last_clk, last_locked}), 32'({tbl[i].ce, tbl[i].ck, tbl[i].lk}));
    end

    // Two writes before the wrap: only the later ratio is applied
    step(1, 0, 6, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(1, 0, 3, 0);
    step(1, 0, 7, 0);
    step(0, 0, 0, 0);
    check("locked_low_pending", 32'(last_locked), 32'(0));
    measure_period(0, per);
    check("overwrite_period", 32'(per), 32'(7));

    // Write landing on the wrap cycle applies immediately without pending
    for (int k = 0; k < 6; k++) step(0, 0, 0, 0);
    step(1, 0, 4, 0);
    lk_ok = 1;
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0);
      if (!last_locked) lk_ok = 0;
    end
    check("wrap_write_no_pend", 32'(lk_ok), 32'(1));
    measure_period(0, per);
    check("wrap_write_period", 32'(per), 32'(4));

    // sync_i with a same-cycle write: ch0=4, ch1=6 coincide every 12 cycles
    step(1, 1, 6, 1);
    both = 0; first_both = -1;
    for (int k = 0; k < 24; k++) begin
      step(0, 0, 0, 0);
      if (last_ce == 2'b11) begin
        both++;
        if (first_both < 0) first_both = k;
      end
    end
    check("sync_coincide_cnt", 32'(both), 32'(2));
    check("sync_coincide_first", 32'(first_both), 32'(11));

    // Ratio 0: channel silent
    step(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0);
    cnt_ce = 0; cnt_clk = 0;
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 0, 0);
      cnt_ce += int'(last_ce[0]); cnt_clk += int'(last_clk[0]);
    end
    check("div0_ce", 32'(cnt_ce), 32'(0));
    check("div0_clk", 32'(cnt_clk), 32'(0));

    // Ratio 1: enable constantly high, clock low
    step(1, 0, 1, 0);
    step(0, 0, 0, 0);
    cnt_ce = 0; cnt_clk = 0;
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 0, 0);
      cnt_ce += int'(last_ce[0]); cnt_clk += int'(last_clk[0]);
    end
    check("div1_ce", 32'(cnt_ce), 32'(10));
    check("div1_clk", 32'(cnt_clk), 32'(0));

    // Ratio 255: one enable per 255 cycles, clock high for 128
    step(1, 0, 255, 0);
    step(0, 0, 0, 1);
    cnt_ce = 0; cnt_clk = 0; per = -1;
    for (int k = 0; k < 255; k++) begin
      step(0, 0, 0, 0);
      cnt_ce += int'(last_ce[0]); cnt_clk += int'(last_clk[0]);
      if (last_ce[0]) per = k;
    end
    check("div255_ce_cnt", 32'(cnt_ce), 32'(1));
    check("div255_ce_pos", 32'(per), 32'(254));
    check("div255_clk_high", 32'(cnt_clk), 32'(128));

    // Asynchronous reset mid-count with a write in flight
    step(1, 0, 3, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0);
    cfg_we_i = 1'b1; cfg_ch_i = '1; cfg_div_i = 8'd9;
    #2 rst_i = 1'b1;
    #1;
    check("async_reset", 32'({rst_o, locked_o, ce_o, clk_o}), 32'({1'b1, 1'b0, 2'b00, 2'b00}));
    model_reset();
    step(1, 1, 9, 0);
    step(0, 0, 0, 0);
    rst_i = 1'b0;
    for (int k = 0; k < RST_HOLD + EXTRA; k++) step(0, 0, 0, 0);
    check("rst_fall_again", 32'({last_rst, rst_o}), 32'(2'b10));
    measure_period(1, per);
    check("default_after_reset", 32'(per), 32'(DEFAULT_DIV));

    // Randomised traffic against the model
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 3) == 0, int'($urandom_range(0, (1 << CH_W) - 1)),
           ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 9)),
           $urandom_range(0, 49) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
